// File: rtl/uart_tx_rr_arbiter.sv
// Packet-atomic round-robin arbiter that shares one uart_tx among NUM_REQ byte sources.
// A byte goes out as a one-cycle tx_valid/req_ack pair, then a two-cycle hold before the next one.
module uart_tx_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int IDLE_TIMEOUT = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           grant,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_SEND, ST_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_q, rr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   hold_q, hold_d;
  logic                   last_q, last_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
  logic                   timeout_q, timeout_d;

  logic [IW:0]            pick_s;
  logic                   owner_valid_s;
  logic                   owner_last_s;
  logic [DATA_BITS-1:0]   owner_data_s;

  // Returns {found, index} of the first valid requester after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    logic [IW:0]   sum;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end else begin
        sum = sum;
      end
      if (v[sum[IW-1:0]]) begin
        found = 1'b1;
        idx   = sum[IW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign pick_s        = rr_pick(req_valid, rr_q);
  assign owner_valid_s = req_valid[owner_q];
  assign owner_last_s  = req_last[owner_q];
  assign owner_data_s  = req_data[owner_q*DATA_BITS +: DATA_BITS];

  // Next-state and registered-output decode for the grant/send/hold sequence.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    last_d     = last_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    ack_d      = '0;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_s[IW]) begin
          owner_d = pick_s[IW-1:0];
          grant_d = NUM_REQ'(1'b1) << pick_s[IW-1:0];
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOCK;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_LOCK: begin
        if (owner_valid_s && tx_ready) begin
          tx_valid_d = 1'b1;
          tx_data_d  = owner_data_s;
          ack_d      = grant_q;
          last_d     = owner_last_s;
          cnt_d      = '0;
          state_d    = ST_SEND;
        end else if (!owner_valid_s) begin
          // Stalled owner: reclaim the transmitter once the idle budget is spent.
          if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            rr_d      = owner_q;
            grant_d   = '0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SEND: begin
        hold_d  = 1'b0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!hold_q) begin
          hold_d = 1'b1;
        end else if (last_q) begin
          rr_d    = owner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCK;
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_q       <= IW'(NUM_REQ - 1);
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      last_q     <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req_ack  = ack_q;
  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Directed bench for uart_tx_rr_arbiter: per-requester byte queues, a paced uart_tx stand-in,
// and one task per scenario with hand-computed expectations.
module tb_uart_tx_rr_arbiter;

  localparam int NR = 4;
  localparam int DB = 8;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DB-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     grant;
  logic [DB-1:0]     tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pair_err = 0;
  int frame_len = 20;
  int ucnt;
  bit drv_en = 1'b1;

  logic [8:0]  qd [NR][$];
  logic [7:0]  tx_log[$];
  int          tx_cyc_log[$];
  int          ack_log[$];
  int          ack_cyc_log[$];
  int          to_log[$];
  logic [NR-1:0] to_grant_log[$];

  uart_tx_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart_tx stand-in: ready falls the cycle after tx_valid and stays low for frame_len cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt <= 0;
    else if (tx_valid) ucnt <= frame_len;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end
  assign tx_ready = (ucnt == 0);

  // Monitor and requester driver, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (tx_valid === 1'b1) begin tx_log.push_back(tx_data); tx_cyc_log.push_back(cyc); end
      for (int i = 0; i < NR; i++) if (req_ack[i] === 1'b1) begin ack_log.push_back(i); ack_cyc_log.push_back(cyc); end
      if (tx_valid !== (|req_ack)) pair_err = pair_err + 1;
      if (timeout === 1'b1) begin to_log.push_back(cyc); to_grant_log.push_back(grant); end
      if (drv_en) begin
        for (int i = 0; i < NR; i++) begin
          if (req_ack[i] === 1'b1 && qd[i].size() > 0) void'(qd[i].pop_front());
          if (qd[i].size() > 0) begin
            req_valid[i] = 1'b1;
            req_data[i*DB +: DB] = qd[i][0][7:0];
            req_last[i] = qd[i][0][8];
          end else begin
            req_valid[i] = 1'b0;
            req_data[i*DB +: DB] = 8'h00;
            req_last[i] = 1'b0;
          end
        end
      end
    end
  end

  function automatic bit idle_done();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (qd[i].size() > 0) e = 1'b0;
    return e && (busy === 1'b0) && (grant === 4'b0000);
  endfunction

  task automatic clear_logs();
    tx_log.delete(); tx_cyc_log.delete(); ack_log.delete(); ack_cyc_log.delete();
    to_log.delete(); to_grant_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_en = 1'b1;
    for (int i = 0; i < NR; i++) qd[i].delete();
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad = 0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (req_ack !== 4'b0000) begin errors++; $display("FAIL reset_req_ack: got %b expected 0000", req_ack); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (grant !== 4'b0000 || busy !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_idle: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_latency();
    do_reset();
    frame_len = 20;
    drv_en = 1'b0;
    req_valid = 4'b0001; req_data = 32'h0000_00A5; req_last = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL lat_grant: got %b/%b expected 0001/1", grant, busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL lat_early_tx: got %b expected 0", tx_valid); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL lat_tx: got %b/%h expected 1/a5", tx_valid, tx_data); end
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL lat_ack: got %b expected 0001", req_ack); end
    req_valid = 4'b0000; req_last = 4'b0000;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || req_ack !== 4'b0000) begin errors++; $display("FAIL lat_pulse: got %b/%b expected 0/0000", tx_valid, req_ack); end
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lat_hold_grant: got %b expected 0001", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL lat_release: got %b/%b expected 0000/0", grant, busy); end
    drv_en = 1'b1;
  endtask

  task automatic test_single_packet();
    int n = 0;
    int bad = 0;
    logic [7:0] exp_b [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    frame_len = 1000;
    qd[0].push_back(9'h011); qd[0].push_back(9'h022); qd[0].push_back(9'h133);
    @(negedge clk);
    while (!idle_done() && n < 6000) begin
      @(negedge clk); n++;
      if (busy === 1'b1 && grant !== 4'b0001) bad++;
      if (busy === 1'b0 && grant !== 4'b0000) bad++;
    end
    checks++; if (n >= 6000) begin errors++; $display("FAIL pkt_done: got timeout expected idle"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL pkt_grant: got %0d bad cycles expected 0", bad); end
    checks++;
    if (tx_log.size() != 3) begin errors++; $display("FAIL pkt_count: got %0d expected 3", tx_log.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (tx_log[k] !== exp_b[k]) begin errors++; $display("FAIL pkt_byte%0d: got %h expected %h", k, tx_log[k], exp_b[k]); end
        checks++; if (ack_log[k] != 0) begin errors++; $display("FAIL pkt_ack%0d: got %0d expected 0", k, ack_log[k]); end
      end
      checks++; if (tx_cyc_log[1] - tx_cyc_log[0] != 1002) begin errors++; $display("FAIL pkt_pace: got %0d expected 1002", tx_cyc_log[1] - tx_cyc_log[0]); end
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    do_reset();
    frame_len = 20;
    qd[1].push_back(9'h141); qd[2].push_back(9'h152);
    while (!idle_done() && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (ack_log.size() != 2 || tx_log.size() != 2) begin errors++; $display("FAIL sim_count: got %0d expected 2", ack_log.size()); end
    else begin
      checks++; if (ack_log[0] != 1 || ack_log[1] != 2) begin errors++; $display("FAIL sim_order: got %0d,%0d expected 1,2", ack_log[0], ack_log[1]); end
      checks++; if (tx_log[0] !== 8'h41 || tx_log[1] !== 8'h52) begin errors++; $display("FAIL sim_bytes: got %h,%h expected 41,52", tx_log[0], tx_log[1]); end
    end
    clear_logs();
    n = 0;
    qd[1].push_back(9'h161); qd[3].push_back(9'h173);
    while (!idle_done() && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (ack_log.size() != 2) begin errors++; $display("FAIL ptr2_count: got %0d expected 2", ack_log.size()); end
    else if (ack_log[0] != 3 || ack_log[1] != 1) begin errors++; $display("FAIL ptr2_order: got %0d,%0d expected 3,1", ack_log[0], ack_log[1]); end
  endtask

  task automatic test_atomic();
    int n = 0;
    int exp_a [5] = '{0, 0, 0, 0, 3};
    logic [7:0] exp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h3A};
    do_reset();
    frame_len = 20;
    qd[0].push_back(9'h001); qd[0].push_back(9'h002); qd[0].push_back(9'h003); qd[0].push_back(9'h104);
    while (tx_log.size() < 1 && n < 200) begin @(negedge clk); n++; end
    qd[3].push_back(9'h13A);
    n = 0;
    while (!idle_done() && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (ack_log.size() != 5 || tx_log.size() != 5) begin errors++; $display("FAIL atom_count: got %0d expected 5", ack_log.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (ack_log[k] != exp_a[k] || tx_log[k] !== exp_b[k]) begin
          errors++; $display("FAIL atom_seq%0d: got req%0d/%h expected req%0d/%h", k, ack_log[k], tx_log[k], exp_a[k], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    frame_len = 20;
    qd[0].push_back(9'h010); qd[2].push_back(9'h12B);
    while (to_log.size() == 0 && n < 600) begin @(negedge clk); n++; end
    while (!idle_done() && n < 900) begin @(negedge clk); n++; end
    checks++;
    if (to_log.size() != 1 || ack_cyc_log.size() < 1) begin errors++; $display("FAIL to_count: got %0d expected 1", to_log.size()); end
    else begin
      checks++; if (to_log[0] != ack_cyc_log[0] + 259) begin errors++; $display("FAIL to_cycle: got %0d expected %0d", to_log[0], ack_cyc_log[0] + 259); end
      checks++; if (to_grant_log[0] !== 4'b0000) begin errors++; $display("FAIL to_grant: got %b expected 0000", to_grant_log[0]); end
    end
    checks++;
    if (ack_log.size() != 2 || tx_log.size() != 2) begin errors++; $display("FAIL to_next_count: got %0d expected 2", ack_log.size()); end
    else if (ack_log[1] != 2 || tx_log[1] !== 8'h2B) begin errors++; $display("FAIL to_next: got req%0d/%h expected req2/2b", ack_log[1], tx_log[1]); end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    frame_len = 20;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      n = 0;
      qd[0].push_back(9'h10A); qd[3].push_back(9'h13B);
      while (!idle_done() && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (ack_log.size() != 2) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 2", r, ack_log.size()); end
      else if (ack_log[0] != 0 || ack_log[1] != 3) begin errors++; $display("FAIL wrap_order%0d: got %0d,%0d expected 0,3", r, ack_log[0], ack_log[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    frame_len = 0;
    qd[0].push_back(9'h0C1); qd[0].push_back(9'h1C2); qd[0].push_back(9'h1C3);
    while (!idle_done() && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx_cyc_log.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", tx_cyc_log.size()); end
    else begin
      checks++; if (tx_cyc_log[1] - tx_cyc_log[0] != 4) begin errors++; $display("FAIL b2b_rate: got %0d expected 4", tx_cyc_log[1] - tx_cyc_log[0]); end
      checks++; if (tx_cyc_log[2] - tx_cyc_log[1] != 5) begin errors++; $display("FAIL b2b_regrant: got %0d expected 5", tx_cyc_log[2] - tx_cyc_log[1]); end
      checks++; if (tx_log[2] !== 8'hC3) begin errors++; $display("FAIL b2b_byte: got %h expected c3", tx_log[2]); end
    end
  endtask

  task automatic test_reset_in_hold();
    int n = 0;
    int bad = 0;
    do_reset();
    frame_len = 20;
    qd[0].push_back(9'h077); qd[0].push_back(9'h178);
    while (tx_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin errors++; $display("FAIL rh_first: got no tx_valid expected one"); end
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rh_pre_grant: got %b expected 0001", grant); end
    #2 rst_n = 1'b0;
    for (int i = 0; i < NR; i++) qd[i].delete();
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || tx_valid !== 1'b0 || req_ack !== 4'b0000 || tx_data !== 8'h00 || timeout !== 1'b0) begin
      errors++; $display("FAIL rh_async: got %b/%b/%b/%b/%h/%b expected all zero", grant, busy, tx_valid, req_ack, tx_data, timeout);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) bad++;
    end
    checks++; if (bad != 0 || tx_log.size() != 0) begin errors++; $display("FAIL rh_quiet: got %0d active cycles expected 0", bad); end
    qd[1].push_back(9'h199);
    n = 0;
    while (!idle_done() && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (tx_log.size() != 1 || ack_log.size() != 1) begin errors++; $display("FAIL rh_after_count: got %0d expected 1", tx_log.size()); end
    else if (tx_log[0] !== 8'h99 || ack_log[0] != 1) begin errors++; $display("FAIL rh_after: got req%0d/%h expected req1/99", ack_log[0], tx_log[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    test_reset();
    test_latency();
    test_single_packet();
    test_simultaneous();
    test_atomic();
    test_timeout();
    test_wrap();
    test_back_to_back();
    test_reset_in_hold();
    checks++; if (pair_err != 0) begin errors++; $display("FAIL tx_ack_pairing: got %0d mismatched cycles expected 0", pair_err); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
